// File: rtl/tribus_arbiter.sv
// ============================================================================
// tribus_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Two-requester arbiter and sequencer for a shared tristate data bus built
//   around a 2:1 tristate mux. It chooses which agent (d0 or d1) owns the bus
//   and drives the mux select (s) and the bus enable (oe). Between two owners
//   it inserts exactly one high-Z turnaround cycle, so two drivers never
//   overlap on the bus.
//
// Parameters:
//   WIDTH     data bus width in bits (default 4)
//   MAX_HOLD  maximum consecutive GRANT cycles per ownership (default 8).
//             It only limits ownership when ARB_TIMEOUT_EN is defined.
//             Must be >= 1.
//
// Optional feature (compile-time macro):
//   ARB_TIMEOUT_EN  when defined, an owner that keeps requesting is forced
//                   off the bus after MAX_HOLD grant cycles. When it is
//                   undefined, the owner keeps the bus until its req drops.
//
// Ports:
//   clk    in   1      single clock; all state changes on the rising edge
//   reset  in   1      synchronous, active-high reset
//   req    in   2      req[i] high = agent i requests the bus
//   d0     in   WIDTH  data from agent 0
//   d1     in   WIDTH  data from agent 1
//   gnt    out  2      registered grant, one-hot or all zero
//   s      out  1      registered mux select (current or most recent owner)
//   oe     out  1      registered bus enable (gnt[0] | gnt[1])
//   y      out  WIDTH  shared bus: oe ? (s ? d1 : d0) : all-Z
// ============================================================================
module tribus_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       gnt,
    output logic             s,
    output logic             oe,
    output logic [WIDTH-1:0] y
);

    // Hold counter wide enough to hold the value MAX_HOLD itself, because it
    // saturates there.
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

`ifdef ARB_TIMEOUT_EN
    // The cycle whose edge sees this count is the MAX_HOLD-th grant cycle,
    // so the forced release happens at that edge.
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [1:0]      gnt_q,   gnt_d;
    logic            s_q,     s_d;
    logic            oe_q,    oe_d;
    logic            last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic            winner;        // round-robin winner among requesters
    logic            owner_req;     // current owner still requesting
    logic            hold_expired;  // forced release due to hold limit

    // With both agents requesting, the one that did not own the bus last
    // wins. With a single requester, that requester wins (req[1] is then the
    // index of the only high bit). With no requester the value is unused.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_q;
        end
    end

    always_comb begin
        owner_req = s_q ? req[1] : req[0];
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        hold_expired = (cnt_q == HOLD_LAST);
    end
`else
    always_comb begin
        hold_expired = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Defaults: hold every register.
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d = 2'b00;
                if (req != 2'b00) begin
                    state_d = ST_GRANT;
                    gnt_d   = {winner, ~winner};
                    s_d     = winner;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                // The other agent's req is deliberately ignored here; it
                // stays pending and is honoured after the turnaround.
                if (!owner_req || hold_expired) begin
                    state_d = ST_TURN;
                    gnt_d   = 2'b00;
                    last_d  = s_q;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_TURN: begin
                // One-cycle high-Z gap. s keeps the previous owner so the mux
                // does not move while the bus is released.
                gnt_d = 2'b00;
                if (req != 2'b00) begin
                    state_d = ST_GRANT;
                    gnt_d   = {winner, ~winner};
                    s_d     = winner;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        // oe is registered alongside gnt so both change on the same edge.
        oe_d = gnt_d[0] | gnt_d[1];
    end

    // ------------------------------------------------------------------
    // Registers with synchronous active-high reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            s_q     <= 1'b0;
            oe_q    <= 1'b0;
            // last = 1 makes agent 0 win the first simultaneous request.
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            oe_q    <= oe_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt = gnt_q;
    assign s   = s_q;
    assign oe  = oe_q;

    // The data path is live: a change on the owner's input reaches the bus
    // in the same cycle; only select and enable are registered.
    assign y = oe_q ? (s_q ? d1 : d0) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tribus_arbiter.sv
module tb_tribus_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    wire  [1:0]       gnt;
    wire              s;
    wire              oe;
    wire  [WIDTH-1:0] y;

    tribus_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .gnt   (gnt),
        .s     (s),
        .oe    (oe),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] gnt;
        logic       s;
        logic       oe;
        logic [3:0] y;   // only compared when oe is expected high
    } vec_t;

    vec_t vecs[0:63];
    int   nvec;
    int   errors;
    int   checks;

    localparam logic [3:0] A = 4'b1010;
    localparam logic [3:0] B = 4'b0101;
    localparam logic [3:0] C = 4'b0011;

    task automatic add(input logic r, input logic [1:0] rq, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] g, input logic sel,
                       input logic en, input logic [3:0] yy);
        vecs[nvec].rst = r;
        vecs[nvec].req = rq;
        vecs[nvec].d0  = a;
        vecs[nvec].d1  = b;
        vecs[nvec].gnt = g;
        vecs[nvec].s   = sel;
        vecs[nvec].oe  = en;
        vecs[nvec].y   = yy;
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] g,
                                 input logic sel, input logic en, input logic [3:0] yy);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".s"},   32'(s),   32'(sel));
        chk({tag, ".oe"},  32'(oe),  32'(en));
        if (en) chk({tag, ".y"}, 32'(y), 32'(yy));
        // Structural invariants checked every cycle
        chk({tag, ".not11"}, 32'(gnt == 2'b11), 32'd0);
        chk({tag, ".oe_eq"}, 32'(oe), 32'(gnt[0] | gnt[1]));
    endtask

    logic [1:0] prev_gnt;

    initial begin
        errors   = 0;
        checks   = 0;
        nvec     = 0;
        prev_gnt = 2'b00;

        // ---- Reset with both requesting, release -> agent 0 wins
        add(1, 2'b11, A, B, 2'b00, 0, 0, A);
        add(1, 2'b11, A, B, 2'b00, 0, 0, A);
        add(0, 2'b11, A, B, 2'b01, 0, 1, A);
        // ---- Simple handoff 0 -> 1
        add(0, 2'b01, A, B, 2'b01, 0, 1, A);
        add(0, 2'b01, A, B, 2'b01, 0, 1, A);
        add(0, 2'b10, A, B, 2'b00, 0, 0, A);   // TURN, s holds
        add(0, 2'b10, A, B, 2'b10, 1, 1, B);
        // ---- Round robin with one-cycle drops
        add(0, 2'b11, A, B, 2'b10, 1, 1, B);
        add(0, 2'b01, A, B, 2'b00, 1, 0, B);   // owner 1 drops
        add(0, 2'b11, A, B, 2'b01, 0, 1, A);   // last=1 -> agent 0
        add(0, 2'b11, A, B, 2'b01, 0, 1, A);
        add(0, 2'b10, A, B, 2'b00, 0, 0, A);   // owner 0 drops
        add(0, 2'b11, A, B, 2'b10, 1, 1, B);   // last=0 -> agent 1
        // ---- Re-grant same agent after turnaround, then idle
        add(0, 2'b10, A, B, 2'b10, 1, 1, B);
        add(0, 2'b00, A, B, 2'b00, 1, 0, B);
        add(0, 2'b10, A, B, 2'b10, 1, 1, B);
        add(0, 2'b00, A, B, 2'b00, 1, 0, B);   // TURN
        add(0, 2'b00, A, B, 2'b00, 1, 0, B);   // IDLE, s still 1
        add(0, 2'b01, A, B, 2'b01, 0, 1, A);
        // ---- Both held: hold limit (MAX_HOLD=4) or indefinite hold
        add(0, 2'b11, A, B, 2'b01, 0, 1, A);
        add(0, 2'b11, A, B, 2'b01, 0, 1, A);
        add(0, 2'b11, A, B, 2'b01, 0, 1, A);
`ifdef ARB_TIMEOUT_EN
        add(0, 2'b11, A, B, 2'b00, 0, 0, A);
        add(0, 2'b11, A, B, 2'b10, 1, 1, B);
        add(0, 2'b11, A, B, 2'b10, 1, 1, B);
        add(0, 2'b11, A, B, 2'b10, 1, 1, B);
        add(0, 2'b11, A, B, 2'b10, 1, 1, B);
        add(0, 2'b11, A, B, 2'b00, 1, 0, B);
        add(0, 2'b11, A, B, 2'b01, 0, 1, A);
`else
        for (int k = 0; k < 7; k++) add(0, 2'b11, A, B, 2'b01, 0, 1, A);
`endif
        // ---- Hand over to agent 1, then data tracking on d1
        add(0, 2'b10, A, B, 2'b00, 0, 0, A);
        add(0, 2'b10, A, B, 2'b10, 1, 1, B);
        add(0, 2'b10, A, C, 2'b10, 1, 1, C);

        reset = 1'b0;
        req   = 2'b00;
        d0    = A;
        d1    = B;

        for (int i = 0; i < nvec; i++) begin
            reset = vecs[i].rst;
            req   = vecs[i].req;
            d0    = vecs[i].d0;
            d1    = vecs[i].d1;
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%b req=%b -> gnt=%b s=%b oe=%b y=%b (exp gnt=%b s=%b oe=%b)",
                     i, reset, req, gnt, s, oe, y, vecs[i].gnt, vecs[i].s, vecs[i].oe);
            check_outputs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].s, vecs[i].oe, vecs[i].y);
            // Never switch owner without a zero cycle in between.
            chk($sformatf("vec%0d.nogap", i),
                32'((prev_gnt == 2'b01 && gnt == 2'b10) || (prev_gnt == 2'b10 && gnt == 2'b01)),
                32'd0);
            prev_gnt = gnt;
        end

        // ---- Same-cycle data propagation while agent 1 owns the bus
        #2;
        d1 = 4'b0110;
        #1;
        $display("mid-cycle d1 change: y=%b", y);
        chk("live_d1", 32'(y), 32'(4'b0110));
        d0 = 4'b1111;   // non-owner data must not reach the bus
        #1;
        $display("mid-cycle d0 change: y=%b", y);
        chk("ignore_d0", 32'(y), 32'(4'b0110));

        // ---- Reset mid-grant: no turnaround, immediate release
        reset = 1'b1;
        req   = 2'b10;
        @(posedge clk);
        #1;
        $display("reset mid-grant: gnt=%b s=%b oe=%b", gnt, s, oe);
        check_outputs("rst_mid", 2'b00, 1'b0, 1'b0, 4'b0000);

        // ---- Req pulse between edges is not seen
        reset = 1'b0;
        req   = 2'b00;
        @(posedge clk);
        #2;
        req = 2'b01;
        #3;
        req = 2'b00;
        @(posedge clk);
        #1;
        $display("short pulse: gnt=%b oe=%b", gnt, oe);
        check_outputs("pulse", 2'b00, 1'b0, 1'b0, 4'b0000);

        // ---- After reset, last=1 again so agent 0 wins a tie
        req = 2'b11;
        @(posedge clk);
        #1;
        $display("post-reset tie: gnt=%b s=%b oe=%b y=%b", gnt, s, oe, y);
        check_outputs("tie_after_rst", 2'b01, 1'b0, 1'b1, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, actual=running required=done");
        $fatal(1, "timeout");
    end

endmodule
